// File: rtl/ws2812_pixel_gen.sv
// Pixel source for a WS2812 serializer: one GRB word per LED per frame,
// rainbow hue wheel across the strip with a triangle brightness envelope.
module ws2812_pixel_gen #(
    parameter int LED_NUM     = 8,
    parameter int CLK_FRE     = 27_000_000,
    parameter int FRAME_HZ    = 50,
    parameter int HUE_STEP    = 32,
    parameter int BRIGHT_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        frame_busy,
    output logic        frame_drop
);

    localparam int FRAME_PERIOD = CLK_FRE / FRAME_HZ;
    localparam int TW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int IW = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(FRAME_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(LED_NUM - 1);
    localparam logic [7:0]    STEP8      = 8'(BRIGHT_STEP);

    typedef enum logic { IDLE, SEND } state_t;
    typedef enum logic { DIR_UP, DIR_DOWN } dir_t;

    // Hue wheel: three linear segments of 85 steps, then scaled by brightness.
    function automatic logic [23:0] color(input logic [7:0] hue_base,
                                          input logic [IW-1:0] i,
                                          input logic [7:0] br);
        logic [31:0] off;
        logic [7:0]  h, k, k3, r, g, b;
        logic [15:0] pr, pg, pb;
        off = 32'(i) * 32'(HUE_STEP);
        h   = hue_base + off[7:0];
        if (h < 8'd85) begin
            k = h;
        end else if (h < 8'd170) begin
            k = h - 8'd85;
        end else begin
            k = h - 8'd170;
        end
        k3 = {k[6:0], 1'b0} + k;
        if (h < 8'd85) begin
            r = 8'd255 - k3; g = k3;           b = 8'd0;
        end else if (h < 8'd170) begin
            r = 8'd0;        g = 8'd255 - k3;  b = k3;
        end else begin
            r = k3;          g = 8'd0;         b = 8'd255 - k3;
        end
        pr = {8'd0, r} * {8'd0, br};
        pg = {8'd0, g} * {8'd0, br};
        pb = {8'd0, b} * {8'd0, br};
        return {pg[15:8], pr[15:8], pb[15:8]};
    endfunction

    state_t        state_q, state_d;
    dir_t          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    base_hue_q, base_hue_d;
    logic [7:0]    bright_q, bright_d;
    logic [23:0]   pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic          pix_last_q, pix_last_d;
    logic          frame_busy_q, frame_busy_d;
    logic          frame_drop_q, frame_drop_d;

    logic          tick;
    logic [IW-1:0] idx_next;
    logic [8:0]    up_sum;
    logic [23:0]   next_color;

    assign tick     = (timer_q == TIMER_LAST);
    assign idx_next = idx_q + 1'b1;
    assign up_sum   = {1'b0, bright_q} + {1'b0, STEP8};

    // NOTE: every *_d gets a default before any branch, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        timer_d      = tick ? '0 : timer_q + 1'b1;
        idx_d        = idx_q;
        base_hue_d   = base_hue_q;
        bright_d     = bright_q;
        pix_data_d   = pix_data_q;
        pix_valid_d  = pix_valid_q;
        pix_last_d   = pix_last_q;
        frame_drop_d = 1'b0;
        next_color   = color(base_hue_q, (state_q == SEND) ? idx_next : '0, bright_q);

        case (state_q)
            IDLE: begin
                if (tick && en) begin
                    idx_d       = '0;
                    pix_data_d  = next_color;
                    pix_valid_d = 1'b1;
                    pix_last_d  = (LED_NUM == 1);
                    state_d     = SEND;
                end
            end
            SEND: begin
                // A tick that lands mid-frame is dropped, not queued.
                if (tick) begin
                    frame_drop_d = 1'b1;
                end
                if (pix_valid_q && pix_ready) begin
                    if (pix_last_q) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        state_d     = IDLE;
                        base_hue_d  = base_hue_q + 8'd1;
                        if (dir_q == DIR_UP) begin
                            if (up_sum >= 9'd255) begin
                                bright_d = 8'd255;
                                dir_d    = DIR_DOWN;
                            end else begin
                                bright_d = up_sum[7:0];
                            end
                        end else begin
                            if (bright_q <= STEP8) begin
                                bright_d = 8'd0;
                                dir_d    = DIR_UP;
                            end else begin
                                bright_d = bright_q - STEP8;
                            end
                        end
                    end else begin
                        idx_d      = idx_next;
                        pix_data_d = next_color;
                        pix_last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        frame_busy_d = (state_d == SEND);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            dir_q        <= DIR_UP;
            timer_q      <= '0;
            idx_q        <= '0;
            base_hue_q   <= '0;
            bright_q     <= '0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_last_q   <= 1'b0;
            frame_busy_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            base_hue_q   <= base_hue_d;
            bright_q     <= bright_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            pix_last_q   <= pix_last_d;
            frame_busy_q <= frame_busy_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_last   = pix_last_q;
    assign frame_busy = frame_busy_q;
    assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_ws2812_pixel_gen.sv
// Scoreboard bench for ws2812_pixel_gen: the stimulus thread queues expected
// words, a monitor pops and compares on every accepted handshake.
module tb_ws2812_pixel_gen;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        frame_busy;
    logic        frame_drop;

    ws2812_pixel_gen #(
        .LED_NUM    (3),
        .CLK_FRE    (1000),
        .FRAME_HZ   (10),
        .HUE_STEP   (85),
        .BRIGHT_STEP(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .frame_busy(frame_busy),
        .frame_drop(frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   drops_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference colour: frame n has base_hue=n and a closed-form triangle brightness.
    function automatic logic [23:0] model_word(input int n, input int i);
        int br, h, k, r, g, b;
        if (n <= 31)      br = 8 * n;
        else if (n == 32) br = 255;
        else              br = 255 - 8 * (n - 32);
        h = (n + i * 85) % 256;
        if (h < 85)       begin r = 255 - 3 * h; g = 3 * h;       b = 0;           end
        else if (h < 170) begin k = h - 85;  r = 0;           g = 255 - 3 * k; b = 3 * k;  end
        else              begin k = h - 170; r = 3 * k;       g = 0;           b = 255 - 3 * k; end
        return {8'((g * br) / 256), 8'((r * br) / 256), 8'((b * br) / 256)};
    endfunction

    task automatic push_word(input logic [23:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        sb_q.push_back(e);
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < 3; i++) push_word(model_word(n, i), i == 2);
    endtask

    task automatic wait_start(input int limit, output int cycles);
        cycles = 0;
        while (!pix_valid && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("frame_start", pix_valid, 1);
    endtask

    task automatic wait_end(input int limit, output int cycles);
        cycles = 0;
        while (pix_valid && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("frame_end", pix_valid, 0);
    endtask

    // Monitor: compare every accepted word against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_drop) drops_seen++;
            if (rst_n && pix_valid && pix_ready) begin
                check("sb_has_entry", 32'(sb_q.size() != 0), 1);
                check("busy_while_valid", frame_busy, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("word_data", pix_data, e.data);
                    check("word_last", pix_last, e.last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, wanted completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, since_drop, busy_hits;
        rst_n     = 1'b0;
        en        = 1'b1;
        pix_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {pix_valid, pix_last, frame_busy, frame_drop}, 4'b0000);
        check("rst_data", pix_data, 24'h000000);

        // Frame 0: bright=0, everything black; latency from reset release.
        push_word(24'h000000, 1'b0);
        push_word(24'h000000, 1'b0);
        push_word(24'h000000, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        wait_start(200, c);
        check("first_frame_latency", c, 100);
        wait_end(10, c);

        // Frame 1: bright=8, base_hue=1, back-to-back words.
        push_word(24'h000700, 1'b0);
        push_word(24'h070000, 1'b0);
        push_word(24'h000007, 1'b1);
        wait_start(200, c);
        check("frame_spacing", c, 97);
        wait_end(10, c);
        check("burst_cycles", c, 3);

        // Frame 2: stall word 1 for five cycles.
        push_word(24'h000F00, 1'b0);
        push_word(24'h0F0000, 1'b0);
        push_word(24'h00000F, 1'b1);
        wait_start(200, c);
        @(posedge clk); #1;
        pix_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clk); #1;
            check("stall_hold", {pix_valid, pix_last, pix_data}, {1'b1, 1'b0, 24'h0F0000});
        end
        pix_ready = 1'b1;
        wait_end(10, c);
        check("stall_tail_cycles", c, 2);

        // Frames 3..39: breathing envelope and hue advance.
        for (int n = 3; n < 40; n++) begin
            push_frame(n);
            wait_start(200, c);
            wait_end(10, c);
        end

        // Frame 40: hold pix_ready low across the next tick.
        pix_ready = 1'b0;
        push_frame(40);
        wait_start(200, c);
        c = 0;
        while (!frame_drop && c < 150) begin
            @(posedge clk); #1;
            c++;
        end
        check("drop_pulse", frame_drop, 1);
        check("hold_across_tick", {pix_valid, pix_data}, {1'b1, model_word(40, 0)});
        @(posedge clk); #1;
        check("drop_width", frame_drop, 0);
        since_drop = 1;
        pix_ready  = 1'b1;
        wait_end(10, c2);
        since_drop += c2;

        // Frame 41: next frame waits for the following tick; en drops mid-frame.
        push_frame(41);
        wait_start(200, c);
        since_drop += c;
        check("restart_after_drop", since_drop, 100);
        en = 1'b0;
        wait_end(10, c);

        busy_hits = 0;
        for (int s = 0; s < 250; s++) begin
            @(posedge clk); #1;
            if (pix_valid || frame_drop || frame_busy) busy_hits++;
        end
        check("en_off_idle", busy_hits, 0);

        // Frame 42: reset while word 1 is stalled.
        en = 1'b1;
        push_word(model_word(42, 0), 1'b0);
        wait_start(200, c);
        @(posedge clk); #1;
        pix_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {pix_valid, pix_last, frame_busy}, 3'b000);
        check("async_rst_data", pix_data, 24'h000000);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        pix_ready = 1'b1;

        push_word(24'h000000, 1'b0);
        push_word(24'h000000, 1'b0);
        push_word(24'h000000, 1'b1);
        wait_start(200, c);
        check("post_rst_latency", c, 100);
        wait_end(10, c);
        push_word(24'h000700, 1'b0);
        push_word(24'h070000, 1'b0);
        push_word(24'h000007, 1'b1);
        wait_start(200, c);
        wait_end(10, c);

        @(posedge clk); #1;
        check("sb_drained", sb_q.size(), 0);
        check("total_drops", drops_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
